// File: rtl/clksel_pkg.sv
// Shared types for the CPU clock-select sequencer: FSM state encoding and
// divider-select encodings presented to the clock switch.
package clksel_pkg;

  typedef enum logic [2:0] {
    LS_RUN,
    LINGER,
    REQ_HS,
    HS_RUN,
    REQ_LS
  } state_t;

  localparam logic [1:0] DIV_1 = 2'b00;
  localparam logic [1:0] DIV_2 = 2'b01;
  localparam logic [1:0] DIV_4 = 2'b10;

  // States in which the CPU already runs from the slow clock.
  function automatic logic is_ls_domain(input state_t s);
    return (s == LS_RUN) || (s == LINGER);
  endfunction

endpackage

// File: rtl/clksel_seq_sync_bit.sv
// Multi-flop synchroniser for one asynchronous bit, with a selectable
// reset value so the chain can power up in its "idle" level.
module sync_bit #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_b,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sh;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) sh <= {DEPTH{RST_VAL}};
    else        sh <= {sh[DEPTH-2:0], d};
  end

  assign q = sh[DEPTH-1];

endmodule

// File: rtl/clksel_seq.sv
// CPU clock-select sequencer: lingers in low speed before requesting the fast
// clock, handshakes with the clock switch, and falls back on slow accesses.
module clksel_seq
  import clksel_pkg::*;
#(
  parameter int LINGER_CYCLES  = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic       hsclk_in,
  input  logic       rst_b,
  input  logic       hs_en,
  input  logic       slow_req,
  input  logic [1:0] div_cfg,
  input  logic       hs_ack,
  input  logic       ls_ack,
  input  logic       err_clr,
  output logic       hsclk_sel,
  output logic [1:0] cpuclk_div_sel,
  output logic       cpu_rdy,
  output logic       hs_active,
  output logic       err
);

  localparam int LW = (LINGER_CYCLES  > 1) ? $clog2(LINGER_CYCLES)  : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [LW-1:0] LINGER_LOAD = LW'(LINGER_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_nxt;
  logic          hs_s, ls_s;
  logic [LW-1:0] lin_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_last, tmo_hit;

  // hs_ack idles low, ls_ack idles high: the switch starts on the slow clock.
  sync_bit #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_hs_sync (
    .clk(hsclk_in), .rst_b(rst_b), .d(hs_ack), .q(hs_s)
  );
  sync_bit #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_ls_sync (
    .clk(hsclk_in), .rst_b(rst_b), .d(ls_ack), .q(ls_s)
  );

  assign tmo_last = (tmo_cnt == TMO_LAST);

  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) state <= LS_RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tmo_hit   = 1'b0;
    case (state)
      LS_RUN: if (hs_en && !slow_req) state_nxt = LINGER;
      LINGER: begin
        if (slow_req || !hs_en) state_nxt = LS_RUN;
        else if (lin_cnt == '0) state_nxt = REQ_HS;
      end
      // A slow request here does not abort; HS_RUN leaves again next cycle.
      REQ_HS: begin
        if (hs_s && !ls_s) state_nxt = HS_RUN;
        else if (tmo_last) begin
          state_nxt = REQ_LS;
          tmo_hit   = 1'b1;
        end
      end
      HS_RUN: if (slow_req || !hs_en) state_nxt = REQ_LS;
      REQ_LS: begin
        if (ls_s && !hs_s) state_nxt = LS_RUN;
        else if (tmo_last) begin
          state_nxt = LS_RUN;
          tmo_hit   = 1'b1;
        end
      end
      default: state_nxt = LS_RUN;
    endcase
  end

  // Saturating linger and handshake-timeout counters.
  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      lin_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      if (state == LS_RUN && state_nxt == LINGER)
        lin_cnt <= LINGER_LOAD;
      else if (state == LINGER && lin_cnt != '0)
        lin_cnt <= lin_cnt - LW'(1);

      if ((state_nxt == REQ_HS || state_nxt == REQ_LS) && state_nxt != state)
        tmo_cnt <= '0;
      else if ((state == REQ_HS || state == REQ_LS) && !tmo_last)
        tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // Registered outputs; hsclk_sel follows the next state so it changes on the
  // same edge as the state register.
  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      hsclk_sel      <= 1'b0;
      cpuclk_div_sel <= DIV_1;
      err            <= 1'b0;
    end else begin
      hsclk_sel <= (state_nxt == REQ_HS) || (state_nxt == HS_RUN);
      if (is_ls_domain(state)) cpuclk_div_sel <= div_cfg;
      if (tmo_hit)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

  assign cpu_rdy   = !(slow_req && (!rst_b || !is_ls_domain(state)));
  assign hs_active = (state == HS_RUN);

endmodule

// File: tb/tb_clksel_seq.sv
// Self-checking bench for clksel_seq: a stimulus table whose expectations go
// through a scoreboard queue, plus hand-written reset sequences.
module tb_clksel_seq;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       hs_en, slow_req, hs_ack, ls_ack, err_clr;
  logic [1:0] div_cfg;
  logic       hsclk_sel, cpu_rdy, hs_active, err;
  logic [1:0] cpuclk_div_sel;

  int checks = 0;
  int errors = 0;

  clksel_seq #(
    .LINGER_CYCLES(4), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .hsclk_in(clk), .rst_b(rst_b), .hs_en(hs_en), .slow_req(slow_req),
    .div_cfg(div_cfg), .hs_ack(hs_ack), .ls_ack(ls_ack), .err_clr(err_clr),
    .hsclk_sel(hsclk_sel), .cpuclk_div_sel(cpuclk_div_sel), .cpu_rdy(cpu_rdy),
    .hs_active(hs_active), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       hs_en, slow_req;
    logic [1:0] div_cfg;
    logic       hs_ack, ls_ack, err_clr;
    int         n;
    logic       sel;
    logic [1:0] div;
    logic       rdy, act, err;
  } vec_t;

  typedef struct {
    int         idx;
    logic       sel;
    logic [1:0] div;
    logic       rdy, act, err;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  task automatic chk(input string nm, input int idx, input logic [1:0] a, input logic [1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, a, e);
    end
  endtask

  task automatic add(input logic en, input logic sr, input logic [1:0] dc,
                     input logic ha, input logic la, input logic ec, input int n,
                     input logic sel, input logic [1:0] dv, input logic rdy,
                     input logic act, input logic er);
    vec_t v;
    v.hs_en = en; v.slow_req = sr; v.div_cfg = dc; v.hs_ack = ha; v.ls_ack = la;
    v.err_clr = ec; v.n = n; v.sel = sel; v.div = dv; v.rdy = rdy; v.act = act;
    v.err = er;
    tbl.push_back(v);
  endtask

  task automatic check_outputs(input string tag, input logic sel, input logic [1:0] dv,
                               input logic rdy, input logic act, input logic er);
    chk({tag, ".hsclk_sel"}, -1, {1'b0, hsclk_sel}, {1'b0, sel});
    chk({tag, ".div_sel"},   -1, cpuclk_div_sel,    dv);
    chk({tag, ".cpu_rdy"},   -1, {1'b0, cpu_rdy},   {1'b0, rdy});
    chk({tag, ".hs_active"}, -1, {1'b0, hs_active}, {1'b0, act});
    chk({tag, ".err"},       -1, {1'b0, err},       {1'b0, er});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    exp_t e;
    rst_b = 1'b0; hs_en = 1'b0; slow_req = 1'b0; div_cfg = 2'b00;
    hs_ack = 1'b0; ls_ack = 1'b1; err_clr = 1'b0;

    //  en sr div  ha la ec  n  sel div  rdy act err
    add(0, 0, 2'b01, 0, 1, 0, 2,  0, 2'b01, 1, 0, 0);  // LS_RUN loads divider
    add(1, 0, 2'b00, 0, 1, 0, 1,  0, 2'b00, 1, 0, 0);  // enter LINGER
    add(1, 0, 2'b00, 0, 1, 0, 3,  0, 2'b00, 1, 0, 0);  // still lingering
    add(1, 0, 2'b00, 0, 1, 0, 1,  1, 2'b00, 1, 0, 0);  // REQ_HS after 4 linger cycles
    add(1, 0, 2'b00, 1, 0, 0, 2,  1, 2'b00, 1, 0, 0);  // acks in synchroniser
    add(1, 0, 2'b00, 1, 0, 0, 1,  1, 2'b00, 1, 1, 0);  // HS_RUN 3 edges after ack
    add(1, 0, 2'b10, 1, 0, 0, 2,  1, 2'b00, 1, 1, 0);  // divider held in HS_RUN
    add(1, 1, 2'b10, 1, 0, 0, 0,  1, 2'b00, 0, 1, 0);  // cpu_rdy drops same cycle
    add(1, 1, 2'b10, 1, 0, 0, 1,  0, 2'b00, 0, 0, 0);  // REQ_LS, sel drops
    add(1, 1, 2'b10, 0, 1, 0, 2,  0, 2'b00, 0, 0, 0);  // waiting for ls ack
    add(1, 1, 2'b10, 0, 1, 0, 1,  0, 2'b00, 1, 0, 0);  // LS_RUN 3 edges after swap
    add(1, 1, 2'b10, 0, 1, 0, 1,  0, 2'b10, 1, 0, 0);  // divider loads one cycle later
    add(1, 0, 2'b10, 0, 1, 0, 1,  0, 2'b10, 1, 0, 0);  // LINGER count 3
    add(1, 0, 2'b10, 0, 1, 0, 1,  0, 2'b10, 1, 0, 0);  // LINGER count 2
    add(1, 1, 2'b10, 0, 1, 0, 0,  0, 2'b10, 1, 0, 0);  // slow in LINGER keeps rdy
    add(1, 1, 2'b10, 0, 1, 0, 1,  0, 2'b10, 1, 0, 0);  // abort to LS_RUN
    add(1, 0, 2'b10, 0, 1, 0, 4,  0, 2'b10, 1, 0, 0);  // 4 edges: not yet REQ_HS
    add(1, 0, 2'b10, 0, 1, 0, 1,  1, 2'b10, 1, 0, 0);  // 5th edge: REQ_HS
    add(1, 0, 2'b10, 0, 1, 0, 15, 1, 2'b10, 1, 0, 0);  // no hs ack, 15 cycles
    add(1, 0, 2'b10, 0, 1, 0, 1,  0, 2'b10, 1, 0, 1);  // 16th: timeout to REQ_LS
    add(1, 0, 2'b10, 0, 1, 1, 1,  0, 2'b10, 1, 0, 0);  // err_clr clears, LS_RUN
    add(1, 0, 2'b10, 0, 1, 0, 1,  0, 2'b10, 1, 0, 0);  // LINGER
    add(1, 0, 2'b10, 0, 1, 0, 4,  1, 2'b10, 1, 0, 0);  // REQ_HS
    add(1, 1, 2'b10, 0, 1, 0, 0,  1, 2'b10, 0, 0, 0);  // slow in REQ_HS stalls
    add(1, 1, 2'b10, 1, 0, 0, 2,  1, 2'b10, 0, 0, 0);  // request not aborted
    add(1, 1, 2'b10, 1, 0, 0, 1,  1, 2'b10, 0, 1, 0);  // completes to HS_RUN
    add(1, 1, 2'b10, 1, 0, 0, 1,  0, 2'b10, 0, 0, 0);  // leaves next cycle
    add(1, 1, 2'b10, 1, 0, 0, 15, 0, 2'b10, 0, 0, 0);  // no ls ack
    add(1, 1, 2'b10, 1, 0, 1, 1,  0, 2'b10, 1, 0, 1);  // timeout to LS_RUN, set beats clear
    add(1, 0, 2'b10, 0, 1, 0, 5,  1, 2'b10, 1, 0, 1);  // back into REQ_HS

    #2;
    check_outputs("reset_async", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset_held", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_b = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      hs_en = tbl[i].hs_en; slow_req = tbl[i].slow_req; div_cfg = tbl[i].div_cfg;
      hs_ack = tbl[i].hs_ack; ls_ack = tbl[i].ls_ack; err_clr = tbl[i].err_clr;
      e.idx = i; e.sel = tbl[i].sel; e.div = tbl[i].div; e.rdy = tbl[i].rdy;
      e.act = tbl[i].act; e.err = tbl[i].err;
      sb.push_back(e);
      repeat (tbl[i].n) @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard step %0d: queue empty", i);
      end else begin
        e = sb.pop_front();
        chk("hsclk_sel", e.idx, {1'b0, hsclk_sel}, {1'b0, e.sel});
        chk("div_sel",   e.idx, cpuclk_div_sel,    e.div);
        chk("cpu_rdy",   e.idx, {1'b0, cpu_rdy},   {1'b0, e.rdy});
        chk("hs_active", e.idx, {1'b0, hs_active}, {1'b0, e.act});
        chk("err",       e.idx, {1'b0, err},       {1'b0, e.err});
      end
    end

    // Reset mid-REQ_HS with err set: outputs return without a clock edge.
    @(negedge clk);
    err_clr = 1'b0;
    rst_b = 1'b0;
    #1;
    check_outputs("reset_req_hs", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);

    // Come up with the fast clock already acknowledged, then reset in HS_RUN.
    @(negedge clk);
    hs_en = 1'b1; slow_req = 1'b0; hs_ack = 1'b1; ls_ack = 1'b0; div_cfg = 2'b01;
    rst_b = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_outputs("rerun_req_hs", 1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_outputs("rerun_hs_run", 1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    check_outputs("reset_hs_run", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
